// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared widths, op codes and FSM state codes for the multiply/divide unit.
package muldiv_unit_pkg;
  localparam int REG_W = 32;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  typedef logic [REG_W-1:0] reg_bus_t;
  typedef logic [2*REG_W-1:0] double_reg_bus_t;
  localparam logic [1:0] MDU_MULT = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV = 2'b10;
  localparam logic [1:0] MDU_DIVU = 2'b11;
  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_MUL = 2'b01,
    MDU_DIVIDE = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;
endpackage

// File: rtl/muldiv_unit_div_iter_u32.sv
// div_iter_u32: unsigned radix-2 restoring divider, one quotient bit per enabled cycle.
module div_iter_u32
  import muldiv_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [REG_W-1:0] dividend_i,
  input  logic [REG_W-1:0] divisor_i,
  output logic [REG_W-1:0] quo_o,
  output logic [REG_W-1:0] rem_o
);
  reg_bus_t rem_q, quo_q, dvs_q;
  logic [REG_W:0] trial, diff;
  // quo_o/rem_o are the values after the step taken this cycle
  always_comb begin
    trial = {rem_q, quo_q[REG_W-1]};
    diff = trial - {1'b0, dvs_q};
    rem_o = diff[REG_W] ? trial[REG_W-1:0] : diff[REG_W-1:0];
    quo_o = {quo_q[REG_W-2:0], ~diff[REG_W]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (en_i) begin
      rem_q <= rem_o;
      quo_q <= quo_o;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO; DIV_ZERO_FAST_EN enables early divide-by-zero exit.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [REG_W-1:0] opa,
  input  logic [REG_W-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             we,
`ifdef DIV_ZERO_FAST_EN
  output logic             div_zero,
`endif
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);
  mdu_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic uns_q, qneg_q, rneg_q, busy_q, we_q;
  reg_bus_t a_q, b_q, hi_q, lo_q, abs_a, abs_b, q_n, r_n, q_fix, r_fix;
  double_reg_bus_t ext_a, ext_b, prod;
  logic accept, zero_fast, sdiv;
  always_comb begin
    accept = start && !flush && (state_q == MDU_IDLE || state_q == MDU_DONE);
    sdiv = op == MDU_DIV;
    abs_a = (sdiv && opa[REG_W-1]) ? -opa : opa;
    abs_b = (sdiv && opb[REG_W-1]) ? -opb : opb;
`ifdef DIV_ZERO_FAST_EN
    zero_fast = op[1] && opb == ZERO_WORD;
`else
    zero_fast = 1'b0;
`endif
    // low 64 bits of the sign-extended product equal the signed product
    ext_a = {{REG_W{~uns_q & a_q[REG_W-1]}}, a_q};
    ext_b = {{REG_W{~uns_q & b_q[REG_W-1]}}, b_q};
    prod = ext_a * ext_b;
    q_fix = qneg_q ? -q_n : q_n;
    r_fix = rneg_q ? -r_n : r_n;
  end
  div_iter_u32 u_div (
    .clk       (cpu_clk_50M),
    .rst       (cpu_rst),
    .load_i    (accept && op[1]),
    .en_i      (state_q == MDU_DIVIDE),
    .dividend_i(abs_a),
    .divisor_i (abs_b),
    .quo_o     (q_n),
    .rem_o     (r_n)
  );
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= MDU_IDLE;
      cnt_q <= '0;
      uns_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      a_q <= ZERO_WORD;
      b_q <= ZERO_WORD;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
`ifdef DIV_ZERO_FAST_EN
      div_zero <= 1'b0;
`endif
    end else begin
      we_q <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      div_zero <= 1'b0;
`endif
      if (flush) begin
        state_q <= MDU_IDLE;
        busy_q <= 1'b0;
        cnt_q <= '0;
      end else if (accept) begin
        uns_q <= op[0];
        qneg_q <= sdiv && (opa[REG_W-1] ^ opb[REG_W-1]);
        rneg_q <= sdiv && opa[REG_W-1];
        a_q <= opa;
        b_q <= opb;
        cnt_q <= '0;
        if (zero_fast) begin
          state_q <= MDU_DONE;
          busy_q <= 1'b0;
          we_q <= WRITE_ENABLE;
          hi_q <= opa;
          lo_q <= '1;
`ifdef DIV_ZERO_FAST_EN
          div_zero <= 1'b1;
`endif
        end else begin
          state_q <= op[1] ? MDU_DIVIDE : MDU_MUL;
          busy_q <= 1'b1;
        end
      end else if (state_q == MDU_MUL) begin
        {hi_q, lo_q} <= prod;
        we_q <= WRITE_ENABLE;
        state_q <= MDU_DONE;
        busy_q <= 1'b0;
      end else if (state_q == MDU_DIVIDE) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_q <= r_fix;
          lo_q <= q_fix;
          we_q <= WRITE_ENABLE;
          state_q <= MDU_DONE;
          busy_q <= 1'b0;
        end
      end else begin
        state_q <= MDU_IDLE;
        busy_q <= 1'b0;
      end
    end
  end
  assign busy = busy_q;
  assign we = we_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and randomized checks of muldiv_unit with a HI/LO scoreboard.
module tb_muldiv_unit;
  logic cpu_clk_50M = 0, cpu_rst = 1, start = 0, flush = 0;
  logic [1:0] op = 0;
  logic [31:0] opa = 0, opb = 0;
  logic busy, we, div_zero_w;
  logic [31:0] hi_o, lo_o;
  int n_checks = 0, n_errs = 0;
  logic [63:0] sbq[$];
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[14];

  muldiv_unit dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst    (cpu_rst),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .busy       (busy),
    .we         (we),
`ifdef DIV_ZERO_FAST_EN
    .div_zero   (div_zero_w),
`endif
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );
`ifndef DIV_ZERO_FAST_EN
  assign div_zero_w = 1'b0;
`endif

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge cpu_clk_50M) begin
    logic [63:0] e;
    #1;
    if (we === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_we", {hi_o, lo_o}, 64'hx);
      else begin
        e = sbq.pop_front();
        chk("hi", {32'b0, hi_o}, {32'b0, e[63:32]});
        chk("lo", {32'b0, lo_o}, {32'b0, e[31:0]});
      end
    end
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    longint p;
    sa = a;
    sbv = b;
    p = longint'(sa) * longint'(sbv);
    case (o)
      2'b00: return p;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: return {32'(sa % sbv), 32'(sa / sbv)};
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat, cyc;
    logic fz;
    fz = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fz = o[1] && b == 0;
`endif
    lat = !o[1] ? 2 : fz ? 1 : 33;
    sbq.push_back(exp);
    @(negedge cpu_clk_50M);
    start = 1; op = o; opa = a; opb = b;
    @(posedge cpu_clk_50M);
    #1;
    start = 0;
    cyc = 1;
    while (we !== 1'b1 && cyc < 60) begin
      chk("busy_run", {63'b0, busy}, 64'd1);
      @(posedge cpu_clk_50M);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("busy_done", {63'b0, busy}, 64'd0);
    chk("div_zero", {63'b0, div_zero_w}, {63'b0, fz});
  endtask

  task automatic count_we(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge cpu_clk_50M);
      #1;
      if (we === 1'b1) cnt++;
    end
  endtask

  initial begin
    logic [31:0] h0, l0, a, b;
    logic [1:0] o;
    int cnt;
    tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[1]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    tbl[2]  = '{2'b00, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
    tbl[3]  = '{2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tbl[4]  = '{2'b01, 32'h80000000, 32'd2, 64'h00000001_00000000};
    tbl[5]  = '{2'b11, 32'd100, 32'd7, 64'h00000002_0000000E};
    tbl[6]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    tbl[7]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD};
    tbl[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
    tbl[9]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF};
    tbl[11] = '{2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF};
`ifdef DIV_ZERO_FAST_EN
    tbl[12] = '{2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF};
`else
    tbl[12] = '{2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_00000001};
`endif
    tbl[13] = '{2'b11, 32'd3, 32'd10, 64'h00000003_00000000};

    repeat (3) @(posedge cpu_clk_50M);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_we", {63'b0, we}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_div_zero", {63'b0, div_zero_w}, 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst = 0;

    for (int i = 0; i < 14; i++) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    @(posedge cpu_clk_50M);
    #1;
    chk("we_one_cycle", {63'b0, we}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i[0]) b = b >> 20;
      if (b == 0) b = 1;
      if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 3;
      run(o, a, b, model(o, a, b));
    end

    @(negedge cpu_clk_50M);
    h0 = hi_o; l0 = lo_o;
    start = 1; op = 2'b11; opa = 32'd1000; opb = 32'd3;
    @(negedge cpu_clk_50M);
    start = 0;
    repeat (9) @(negedge cpu_clk_50M);
    flush = 1;
    @(posedge cpu_clk_50M);
    #1;
    flush = 0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_we", {63'b0, we}, 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, {h0, l0});
    run(2'b01, 32'd3, 32'd5, 64'd15);
    count_we(40, cnt);
    chk("flush_no_late_we", 64'(cnt), 64'd0);

    @(negedge cpu_clk_50M);
    start = 1; flush = 1; op = 2'b01; opa = 32'd2; opb = 32'd2;
    @(posedge cpu_clk_50M);
    #1;
    start = 0; flush = 0;
    chk("flush_start_busy", {63'b0, busy}, 64'd0);
    count_we(4, cnt);
    chk("flush_start_no_we", 64'(cnt), 64'd0);

    @(negedge cpu_clk_50M);
    start = 1; op = 2'b10; opa = 32'd100; opb = 32'd7;
    @(negedge cpu_clk_50M);
    start = 0;
    repeat (3) @(negedge cpu_clk_50M);
    cpu_rst = 1; start = 1; op = 2'b01;
    @(posedge cpu_clk_50M);
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_we", {63'b0, we}, 64'd0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge cpu_clk_50M);
    cpu_rst = 0; start = 0;
    @(posedge cpu_clk_50M);
    #1;
    chk("rst_start_dropped", {63'b0, busy}, 64'd0);
    count_we(40, cnt);
    chk("rst_no_we", 64'(cnt), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
